// File: rtl/restauracao.sv
// Power-return resume controller: waits for mains to stabilise after an outage,
// then reloads the captured machine state into the main FSM via carga/ack_carga.
module restauracao #(
    parameter int unsigned ESTABILIZA = 16,
    parameter int unsigned TIMEOUT    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       energia,
    input  logic [3:0] estado_registrado,
    input  logic       ack_carga,
    output logic       carga,
    output logic [3:0] estado_restaurado,
    output logic       bloqueio,
    output logic       pronto,
    output logic       erro
);

    localparam int unsigned EW = (ESTABILIZA > 1) ? $clog2(ESTABILIZA) : 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [EW-1:0] EST_FIM = EW'(ESTABILIZA - 1);
    localparam logic [TW-1:0] TO_FIM  = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        NORMAL,
        FALHA,
        ESTABILIZANDO,
        CARREGANDO,
        ERRO
    } estado_t;

    estado_t       estado;
    logic          energia_m;
    logic          energia_s;
    logic [EW-1:0] cnt_est;
    logic [TW-1:0] cnt_to;

    // Synchronizer resets high so no outage is reported out of reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            energia_m <= 1'b1;
            energia_s <= 1'b1;
        end else begin
            energia_m <= energia;
            energia_s <= energia_m;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado            <= NORMAL;
            cnt_est           <= '0;
            cnt_to            <= '0;
            carga             <= 1'b0;
            estado_restaurado <= 4'b0;
            bloqueio          <= 1'b0;
            pronto            <= 1'b0;
            erro              <= 1'b0;
        end else begin
            pronto <= 1'b0;
            case (estado)
                // bloqueio drops one cycle after completion, so it overlaps the pronto pulse
                NORMAL: begin
                    bloqueio <= ~energia_s;
                    if (!energia_s) begin
                        estado <= FALHA;
                    end
                end
                FALHA: begin
                    bloqueio <= 1'b1;
                    if (energia_s) begin
                        estado  <= ESTABILIZANDO;
                        cnt_est <= '0;
                    end
                end
                ESTABILIZANDO: begin
                    bloqueio <= 1'b1;
                    if (!energia_s) begin
                        estado <= FALHA;
                    end else if (cnt_est == EST_FIM) begin
                        if (estado_registrado == 4'b0) begin
                            estado <= NORMAL;
                            pronto <= 1'b1;
                        end else begin
                            estado            <= CARREGANDO;
                            estado_restaurado <= estado_registrado;
                            carga             <= 1'b1;
                            cnt_to            <= '0;
                        end
                    end else begin
                        cnt_est <= cnt_est + EW'(1);
                    end
                end
                // Power loss beats ack, and ack beats timeout
                CARREGANDO: begin
                    bloqueio <= 1'b1;
                    if (!energia_s) begin
                        estado <= FALHA;
                        carga  <= 1'b0;
                    end else if (ack_carga) begin
                        estado <= NORMAL;
                        carga  <= 1'b0;
                        pronto <= 1'b1;
                    end else if (cnt_to == TO_FIM) begin
                        estado <= ERRO;
                        carga  <= 1'b0;
                        erro   <= 1'b1;
                    end else begin
                        cnt_to <= cnt_to + TW'(1);
                    end
                end
                ERRO: begin
                    bloqueio <= 1'b1;
                    if (!energia_s) begin
                        estado <= FALHA;
                        erro   <= 1'b0;
                    end
                end
                default: begin
                    estado <= NORMAL;
                    carga  <= 1'b0;
                    erro   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_restauracao.sv
// Directed bench for restauracao with default parameters (ESTABILIZA=16, TIMEOUT=8).
module tb_restauracao;

    logic       clk;
    logic       reset;
    logic       energia;
    logic [3:0] estado_registrado;
    logic       ack_carga;
    logic       carga;
    logic [3:0] estado_restaurado;
    logic       bloqueio;
    logic       pronto;
    logic       erro;

    int checks   = 0;
    int failures = 0;

    restauracao dut (
        .clk               (clk),
        .reset             (reset),
        .energia           (energia),
        .estado_registrado (estado_registrado),
        .ack_carga         (ack_carga),
        .carga             (carga),
        .estado_restaurado (estado_restaurado),
        .bloqueio          (bloqueio),
        .pronto            (pronto),
        .erro              (erro)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset             = 1'b0;
        energia           = 1'b1;
        estado_registrado = 4'b0101;
        ack_carga         = 1'b0;
        #12;
        check("rst_carga", {3'b0, carga}, 4'd0);
        check("rst_bloq",  {3'b0, bloqueio}, 4'd0);
        check("rst_pronto",{3'b0, pronto}, 4'd0);
        check("rst_erro",  {3'b0, erro}, 4'd0);
        check("rst_est",   estado_restaurado, 4'd0);
        reset = 1'b1;
        tick(3);
        check("idle_bloq", {3'b0, bloqueio}, 4'd0);

        // Normal restore
        energia = 1'b0;
        tick(2);
        check("drop_e1_bloq", {3'b0, bloqueio}, 4'd0);
        tick(1);
        check("drop_e2_bloq", {3'b0, bloqueio}, 4'd1);
        tick(2);
        energia = 1'b1;
        tick(18);
        check("rise_e17_carga", {3'b0, carga}, 4'd0);
        tick(1);
        check("rise_e18_carga", {3'b0, carga}, 4'd1);
        check("rise_e18_est",   estado_restaurado, 4'b0101);
        check("rise_e18_bloq",  {3'b0, bloqueio}, 4'd1);
        tick(3);
        check("wait_carga", {3'b0, carga}, 4'd1);
        ack_carga = 1'b1;
        tick(1);
        ack_carga = 1'b0;
        check("ack_carga",  {3'b0, carga}, 4'd0);
        check("ack_pronto", {3'b0, pronto}, 4'd1);
        check("ack_bloq",   {3'b0, bloqueio}, 4'd1);
        tick(1);
        check("ack1_pronto", {3'b0, pronto}, 4'd0);
        check("ack1_bloq",   {3'b0, bloqueio}, 4'd0);

        // Unstable return restarts the stability count
        energia = 1'b0;
        tick(5);
        energia = 1'b1;
        tick(10);
        check("unst_carga", {3'b0, carga}, 4'd0);
        energia = 1'b0;
        tick(4);
        check("unst_low_carga", {3'b0, carga}, 4'd0);
        energia = 1'b1;
        tick(18);
        check("unst_e17_carga", {3'b0, carga}, 4'd0);
        tick(1);
        check("unst_e18_carga", {3'b0, carga}, 4'd1);
        ack_carga = 1'b1;
        tick(1);
        ack_carga = 1'b0;
        check("unst_pronto", {3'b0, pronto}, 4'd1);
        tick(1);

        // Empty snapshot: nothing loaded, just a pronto pulse
        estado_registrado = 4'b0000;
        energia = 1'b0;
        tick(4);
        energia = 1'b1;
        tick(18);
        check("empty_e17_pronto", {3'b0, pronto}, 4'd0);
        tick(1);
        check("empty_e18_pronto", {3'b0, pronto}, 4'd1);
        check("empty_e18_carga",  {3'b0, carga}, 4'd0);
        check("empty_e18_bloq",   {3'b0, bloqueio}, 4'd1);
        check("empty_est_hold",   estado_restaurado, 4'b0101);
        tick(1);
        check("empty_e19_pronto", {3'b0, pronto}, 4'd0);
        check("empty_e19_bloq",   {3'b0, bloqueio}, 4'd0);

        // Timeout without ack
        estado_registrado = 4'b1010;
        energia = 1'b0;
        tick(4);
        energia = 1'b1;
        tick(19);
        check("to_carga",  {3'b0, carga}, 4'd1);
        check("to_est",    estado_restaurado, 4'b1010);
        estado_registrado = 4'b0011;
        tick(7);
        check("to_c7_carga", {3'b0, carga}, 4'd1);
        check("to_c7_erro",  {3'b0, erro}, 4'd0);
        tick(1);
        check("to_c8_carga", {3'b0, carga}, 4'd0);
        check("to_c8_erro",  {3'b0, erro}, 4'd1);
        check("to_c8_bloq",  {3'b0, bloqueio}, 4'd1);
        check("to_est_hold", estado_restaurado, 4'b1010);
        ack_carga = 1'b1;
        tick(1);
        ack_carga = 1'b0;
        check("erro_ack_pronto", {3'b0, pronto}, 4'd0);
        check("erro_ack_erro",   {3'b0, erro}, 4'd1);
        energia = 1'b0;
        tick(2);
        check("erro_e1_erro", {3'b0, erro}, 4'd1);
        tick(1);
        check("erro_e2_erro", {3'b0, erro}, 4'd0);
        check("erro_e2_bloq", {3'b0, bloqueio}, 4'd1);
        energia = 1'b1;
        tick(19);
        check("retry_carga", {3'b0, carga}, 4'd1);
        check("retry_est",   estado_restaurado, 4'b0011);
        ack_carga = 1'b1;
        tick(1);
        ack_carga = 1'b0;
        check("retry_pronto", {3'b0, pronto}, 4'd1);
        tick(1);

        // Power drop and ack in the same cycle: drop wins
        energia = 1'b0;
        tick(4);
        energia = 1'b1;
        tick(19);
        check("prio_carga_pre", {3'b0, carga}, 4'd1);
        energia = 1'b0;
        tick(2);
        ack_carga = 1'b1;
        tick(1);
        ack_carga = 1'b0;
        check("prio_carga",  {3'b0, carga}, 4'd0);
        check("prio_pronto", {3'b0, pronto}, 4'd0);
        check("prio_bloq",   {3'b0, bloqueio}, 4'd1);
        check("prio_erro",   {3'b0, erro}, 4'd0);

        // Asynchronous reset mid-CARREGANDO
        energia = 1'b1;
        tick(19);
        check("ar_carga_pre", {3'b0, carga}, 4'd1);
        #2;
        reset = 1'b0;
        #1;
        check("ar_carga",  {3'b0, carga}, 4'd0);
        check("ar_bloq",   {3'b0, bloqueio}, 4'd0);
        check("ar_erro",   {3'b0, erro}, 4'd0);
        check("ar_pronto", {3'b0, pronto}, 4'd0);
        check("ar_est",    estado_restaurado, 4'd0);
        #2;
        reset = 1'b1;
        tick(1);
        check("ar_rel_bloq",  {3'b0, bloqueio}, 4'd0);
        check("ar_rel_carga", {3'b0, carga}, 4'd0);
        ack_carga = 1'b1;
        tick(1);
        ack_carga = 1'b0;
        check("ar_ack_pronto", {3'b0, pronto}, 4'd0);
        check("ar_ack_bloq",   {3'b0, bloqueio}, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/restauracao.md
# restauracao

Power-return resume controller for the washing-machine controller; counterpart of the power-fail state capture block. It waits for mains power (`energia`) to be stable after an outage, then reloads the captured machine state (`estado_registrado`) into the main cycle FSM through a request/acknowledge handshake. While power is down or a restore is in progress, it holds the machine in hold (`bloqueio`).

## Interface
- `ESTABILIZA`, 16: number of consecutive cycles synchronized `energia` must stay high before a restore is attempted (≥1).
- `TIMEOUT`, 8: maximum number of cycles `carga` stays high waiting for `ack_carga` (≥1).
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low.
- `energia`  in  1  mains-present flag, asynchronous to `clk`; 1 = power present.
- `estado_registrado`  in  4  state snapshot held by the power-fail capture block.
- `ack_carga`  in  1  main FSM has loaded `estado_restaurado`.
- `carga`  out  1  load request to main FSM.
- `estado_restaurado`  out  4  state to be loaded; valid while `carga`=1.
- `bloqueio`  out  1  hold main FSM; 1 in every state except NORMAL.
- `pronto`  out  1  one-cycle pulse when a restore sequence completes.
- `erro`  out  1  restore timed out; level.

## Operation
- `energia` passes through a 2-flop synchronizer, giving `energia_s`. Both flops reset to 1 so that no outage is seen out of reset.
- FSM states: NORMAL, FALHA, ESTABILIZANDO, CARREGANDO, ERRO. Reset state is NORMAL.
- Rule for all states except NORMAL: `energia_s`=0 → FALHA. This has priority over every other condition, including `ack_carga` and timeout.
- NORMAL: if `energia_s`=0 → FALHA.
- FALHA: if `energia_s`=1 → ESTABILIZANDO. The stability counter is cleared on entry.
- ESTABILIZANDO: the counter increments each cycle. When the counter reaches ESTABILIZA-1 with `energia_s`=1:
  - if `estado_registrado`=0 → NORMAL, with a `pronto` pulse. Nothing is restored.
  - otherwise → CARREGANDO, and `estado_restaurado` is loaded from `estado_registrado`.
- CARREGANDO: `carga`=1. The timeout counter is cleared on entry.
  - `ack_carga`=1 → NORMAL, with a `pronto` pulse.
  - Otherwise the timeout counter increments. When it reaches TIMEOUT-1 with no ack → ERRO.
  - If ack and timeout occur in the same cycle, ack wins.
- ERRO: `erro`=1. Leaves only on `energia_s`=0 (→ FALHA, which gives a retry on the next power return) or on reset.
- `estado_restaurado` is loaded only on entry to CARREGANDO. It holds that value until the next load and ignores later changes to `estado_registrado`.
- `erro` clears on leaving ERRO.
- Counter widths: clog2 of the respective parameter, minimum 1 bit. Counters never wrap, because the state exits at terminal count.

## Timing
- All outputs are registered.
- Reset values: `carga`=0, `estado_restaurado`=0, `bloqueio`=0, `pronto`=0, `erro`=0, FSM=NORMAL, both counters=0. Reset takes effect asynchronously, including mid-sequence.
- Outage detection latency: `energia` low sampled at edge E0 → `bloqueio`=1 after edge E2.
- Restore latency: `energia` high first sampled at edge E0 → ESTABILIZANDO after E2 → `carga`=1 after edge E2+ESTABILIZA.
- `ack_carga` sampled at edge A → `carga`=0 and `pronto`=1 after A; `pronto`=0 and `bloqueio`=0 after A+1.
- Without ack, `carga` is high for exactly TIMEOUT cycles, then `carga`=0 and `erro`=1 on the same edge.
- `ack_carga` is ignored outside CARREGANDO.
- An `energia` glitch shorter than 2 cycles may be missed. This is acceptable.

## Test plan
- Reset: assert `reset`=0 mid-CARREGANDO → `carga`, `bloqueio`, `erro`, `pronto`, `estado_restaurado` are all 0 immediately. After release the FSM is in NORMAL.
- Normal restore (defaults, `estado_registrado`=4'b0101):
  - drop `energia` for 5 cycles → `bloqueio`=1 two edges after the drop;
  - raise `energia` → `carga`=1 with `estado_restaurado`=4'b0101 exactly 18 edges after the first high sample;
  - ack 3 cycles later → `carga`=0, a single `pronto` pulse, then `bloqueio`=0.
- Unstable return: `energia` high for 10 cycles, then low again → no `carga`. Then hold high → `carga` appears 18 edges after the second rise, showing the counter restarted.
- Empty snapshot (`estado_registrado`=0): outage, then stable return → `carga` never rises; `pronto` pulses 18 edges after the rise; `bloqueio`=0 the next cycle.
- Timeout: never ack → `carga` high exactly 8 cycles, then `erro`=1 and `bloqueio`=1. Drop `energia` → `erro`=0, FSM in FALHA. Restore with ack → completes with `pronto`.
- Priority: `energia` drop synchronized in the same cycle as `ack_carga`=1 → FSM goes to FALHA, no `pronto`, `carga`=0.
